// File: rtl/dec_pkg.sv
// Shared opcode constants and default decoded-bundle type.
// Used by instr_decode_stage and dec_skid_buf.
package dec_pkg;

    localparam int OP_RTYPE = 0;
    localparam int OP_ORI   = 12;
    localparam int OP_ANDI  = 13;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_OP_W    = 5;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_FUNC_W  = 7;

    // Bundle layout for the default widths; the top
    // rebuilds the same layout from its own parameters.
    typedef struct packed {
        logic [DEF_XLEN-1:0]    pc;
        logic [DEF_OP_W-1:0]    op;
        logic [DEF_REG_W-1:0]   rs;
        logic [DEF_REG_W-1:0]   rt;
        logic [DEF_REG_W-1:0]   rd;
        logic [DEF_SHAMT_W-1:0] shamt;
        logic [DEF_FUNC_W-1:0]  func;
        logic [DEF_XLEN-1:0]    imm;
        logic                   is_rtype;
        logic                   illegal;
    } dec_bundle_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Modports: slave = stage view, master = driver/monitor view.
interface instr_decode_stage_if #(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 5,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int FUNC_W  = 7,
    parameter int XLEN    = 32
);
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [INSTR_W-1:0] instr_i;
    logic [XLEN-1:0]    pc_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [XLEN-1:0]    pc_o;
    logic [OP_W-1:0]    op_o;
    logic [REG_W-1:0]   rs_o;
    logic [REG_W-1:0]   rt_o;
    logic [REG_W-1:0]   rd_o;
    logic [SHAMT_W-1:0] shamt_o;
    logic [FUNC_W-1:0]  func_o;
    logic [XLEN-1:0]    imm_o;
    logic               is_rtype_o;
    logic               illegal_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, op_o, rs_o, rt_o,
        output rd_o, shamt_o, func_o, imm_o, is_rtype_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, op_o, rs_o, rt_o,
        input  rd_o, shamt_o, func_o, imm_o, is_rtype_o, illegal_o
    );

endinterface

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Ports: clk, rst_n, flush_i, in_valid/ready/data, out_valid/ready/data.
module dec_skid_buf
    import dec_pkg::*;
#(
    parameter type T = dec_bundle_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    T       out_q, out_d;
    T       skid_q, skid_d;
    logic   in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        out_d   = in_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_d  = in_data_i;
                        state_d = TWO;
                    end else if (out_fire && !in_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && out_fire) begin
                        out_d = in_data_i;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is a flop: it reflects room after this cycle.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = out_q;

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: field split, immediate extend, classify.
// Ports: clk, rst_n, bus (instr_decode_stage_if.slave). Option: DEC_ILLEGAL_CHECK_EN.
module instr_decode_stage
    import dec_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 5,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int FUNC_W  = 7,
    parameter int IMM_W   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_OPS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_decode_stage_if.slave  bus
);

    if (OP_W + 3*REG_W + SHAMT_W + FUNC_W != INSTR_W) begin : g_bad_fields
        $error("decode field widths do not sum to INSTR_W");
    end
    if (IMM_W > XLEN) begin : g_bad_imm
        $error("IMM_W must not exceed XLEN");
    end

    localparam int RS_HI = INSTR_W - OP_W - 1;
    localparam int RT_HI = RS_HI - REG_W;
    localparam int RD_HI = RT_HI - REG_W;
    localparam int SH_HI = RD_HI - REG_W;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [SHAMT_W-1:0] shamt;
        logic [FUNC_W-1:0]  func;
        logic [XLEN-1:0]    imm;
        logic               is_rtype;
        logic               illegal;
    } bundle_t;

    bundle_t dec_b;
    bundle_t out_b;

    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] instr;
    logic [OP_W-1:0]    op;
    logic signed [IMM_W-1:0] off_s;
    logic               zext;

    assign instr = bus.instr_i;
    assign op    = instr[INSTR_W-1 -: OP_W];
    assign off_s = instr[IMM_W-1:0];
    assign zext  = (op == OP_W'(OP_ORI)) || (op == OP_W'(OP_ANDI));

    always_comb begin
        dec_b          = '0;
        dec_b.pc       = bus.pc_i;
        dec_b.op       = op;
        dec_b.rs       = instr[RS_HI -: REG_W];
        dec_b.rt       = instr[RT_HI -: REG_W];
        dec_b.rd       = instr[RD_HI -: REG_W];
        dec_b.shamt    = instr[SH_HI -: SHAMT_W];
        dec_b.func     = instr[FUNC_W-1:0];
        dec_b.imm      = zext ? XLEN'(unsigned'(off_s))
                              : XLEN'(off_s);
        dec_b.is_rtype = (op == OP_W'(OP_RTYPE));
`ifdef DEC_ILLEGAL_CHECK_EN
        dec_b.illegal  = (32'(op) >= NUM_OPS);
`else
        dec_b.illegal  = 1'b0;
`endif
    end

    dec_skid_buf #(
        .T (bundle_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.flush_i),
        .in_valid_i  (bus.in_valid_i),
        .in_ready_o  (in_ready),
        .in_data_i   (dec_b),
        .out_valid_o (out_valid),
        .out_ready_i (bus.out_ready_i),
        .out_data_o  (out_b)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.pc_o        = out_b.pc;
    assign bus.op_o        = out_b.op;
    assign bus.rs_o        = out_b.rs;
    assign bus.rt_o        = out_b.rt;
    assign bus.rd_o        = out_b.rd;
    assign bus.shamt_o     = out_b.shamt;
    assign bus.func_o      = out_b.func;
    assign bus.imm_o       = out_b.imm;
    assign bus.is_rtype_o  = out_b.is_rtype;
`ifdef DEC_ILLEGAL_CHECK_EN
    assign bus.illegal_o   = out_b.illegal;
`else
    assign bus.illegal_o   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage.
// Covers decode, extension, skid stall, streaming, flush, reset.
module tb_instr_decode_stage;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wrd(input int rd);
        logic [31:0] w;
        w = 32'h1800_0000 | (32'(rd) << 12);
        return w;
    endfunction

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b0;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.pc_i        = '0;
        bus.out_ready_i = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_pc", 64'(bus.pc_o), 64'd0);
        chk("rst_imm", 64'(bus.imm_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // R-type word with negative offset
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = 32'h0000_8000;
        bus.pc_i        = 32'h100;
        bus.out_ready_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        chk("t1_valid", 64'(bus.out_valid_o), 64'd1);
        chk("t1_op", 64'(bus.op_o), 64'd0);
        chk("t1_rd", 64'(bus.rd_o), 64'd8);
        chk("t1_rtype", 64'(bus.is_rtype_o), 64'd1);
        chk("t1_imm", 64'(bus.imm_o), 64'hFFFF_8000);
        chk("t1_pc", 64'(bus.pc_o), 64'h100);
        chk("t1_func", 64'(bus.func_o), 64'd0);
        tick();
        chk("t1_drain", 64'(bus.out_valid_o), 64'd0);

        // Zero-extended ORI then ANDI back to back
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'h6000_8001;
        bus.pc_i       = 32'h104;
        tick();
        chk("t2_ori_imm", 64'(bus.imm_o), 64'h0000_8001);
        chk("t2_ori_op", 64'(bus.op_o), 64'd12);
        chk("t2_ori_rtype", 64'(bus.is_rtype_o), 64'd0);
        bus.instr_i = 32'h6800_FFFF;
        bus.pc_i    = 32'h108;
        tick();
        chk("t2_andi_imm", 64'(bus.imm_o), 64'h0000_FFFF);
        chk("t2_andi_pc", 64'(bus.pc_o), 64'h108);
        bus.instr_i = 32'h1800_FFFF;
        tick();
        chk("t2_sext_imm", 64'(bus.imm_o), 64'hFFFF_FFFF);
        chk("t2_sext_func", 64'(bus.func_o), 64'h7F);
        chk("t2_sext_shamt", 64'(bus.shamt_o), 64'h1F);
        bus.in_valid_i = 1'b0;
        tick();

        // Stall: 3 words offered, 2 accepted
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = wrd(1);
        tick();
        chk("t3_rdy1", 64'(bus.in_ready_o), 64'd1);
        chk("t3_rd1", 64'(bus.rd_o), 64'd1);
        bus.instr_i = wrd(2);
        tick();
        chk("t3_rdy2", 64'(bus.in_ready_o), 64'd0);
        chk("t3_hold_a", 64'(bus.rd_o), 64'd1);
        bus.instr_i = wrd(3);
        tick();
        chk("t3_rdy3", 64'(bus.in_ready_o), 64'd0);
        chk("t3_hold_b", 64'(bus.rd_o), 64'd1);
        chk("t3_valid", 64'(bus.out_valid_o), 64'd1);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        chk("t3_second", 64'(bus.rd_o), 64'd2);
        chk("t3_rdy_back", 64'(bus.in_ready_o), 64'd1);
        chk("t3_valid2", 64'(bus.out_valid_o), 64'd1);
        tick();
        chk("t3_empty", 64'(bus.out_valid_o), 64'd0);

        // Back-to-back stream
        bus.in_valid_i = 1'b1;
        for (int k = 4; k < 8; k++) begin
            bus.instr_i = wrd(k);
            tick();
            chk("t4_rd", 64'(bus.rd_o), 64'(k));
            chk("t4_rdy", 64'(bus.in_ready_o), 64'd1);
            chk("t4_valid", 64'(bus.out_valid_o), 64'd1);
        end
        bus.in_valid_i = 1'b0;
        tick();
        chk("t4_empty", 64'(bus.out_valid_o), 64'd0);

        // Flush while full with a word offered
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = wrd(9);
        tick();
        bus.instr_i = wrd(10);
        tick();
        chk("t5_full", 64'(bus.in_ready_o), 64'd0);
        bus.flush_i = 1'b1;
        bus.instr_i = wrd(11);
        tick();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("t5_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t5_rdy", 64'(bus.in_ready_o), 64'd1);
        bus.out_ready_i = 1'b1;
        tick();
        chk("t5_gone", 64'(bus.out_valid_o), 64'd0);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = wrd(12);
        tick();
        bus.in_valid_i = 1'b0;
        chk("t5_after", 64'(bus.rd_o), 64'd12);
        tick();
        chk("t5_after_empty", 64'(bus.out_valid_o), 64'd0);

        // Out-of-range opcode
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'hF800_0000;
        tick();
        bus.in_valid_i = 1'b0;
        chk("t6_op", 64'(bus.op_o), 64'd31);
`ifdef DEC_ILLEGAL_CHECK_EN
        chk("t6_illegal", 64'(bus.illegal_o), 64'd1);
`else
        chk("t6_illegal", 64'(bus.illegal_o), 64'd0);
`endif
        tick();

        // Asynchronous reset while full
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = wrd(5);
        bus.pc_i        = 32'h300;
        tick();
        tick();
        chk("t7_full", 64'(bus.in_ready_o), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t7_rdy", 64'(bus.in_ready_o), 64'd1);
        chk("t7_rd", 64'(bus.rd_o), 64'd0);
        chk("t7_pc", 64'(bus.pc_o), 64'd0);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_stay_empty", 64'(bus.out_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
